id_issue_ctrl: RTL and testbench

Issue controller for the decode (ID) stage of the 5-stage RV32I pipeline. It holds the single IF/ID pipeline register and a 32-entry busy scoreboard of in-flight load destinations. It also applies a valid/ready handshake toward IF and EX. It stalls an instruction in ID until its source and destination registers are free of pending loads, and squashes it on a branch/jump redirect flush.

---
 rtl/id_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_id_issue_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : id_issue_ctrl
// Purpose : IF/ID register with a load-busy scoreboard and a valid/ready
//           issue handshake for a 5-stage RV32I pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module id_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_inst_q,  id_inst_d;
    logic [31:0]      id_pc_q,    id_pc_d;
    logic [31:0]      busy_q,     busy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, writes_rd, is_load;
    logic       hazard_w, out_valid_w, fire, in_ready_w, accept;

    assign opcode = id_inst_q[6:0];
    assign rs1    = id_inst_q[19:15];
    assign rs2    = id_inst_q[24:20];
    assign rd     = id_inst_q[11:7];

    // Unknown opcodes claim no registers so EX can trap them without stalling.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                writes_rd = 1'b1;
            end
            OP_JALR, OP_ALUI: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_ALU: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: begin
                uses_rs1  = 1'b0;
            end
        endcase
    end

    // The rd term holds back a write that would race a pending load (WAW).
    assign hazard_w    = id_valid_q & ((uses_rs1  & busy_q[rs1]) |
                                       (uses_rs2  & busy_q[rs2]) |
                                       (writes_rd & busy_q[rd]));
    assign out_valid_w = id_valid_q & ~hazard_w & ~flush;
    assign fire        = out_valid_w & out_ready;
    assign in_ready_w  = ~flush & (~id_valid_q | fire);
    assign accept      = in_valid & in_ready_w;

    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (accept) begin
            id_valid_d = 1'b1;
            id_inst_d  = in_inst;
            id_pc_d    = in_pc;
        end else if (fire) begin
            id_valid_d = 1'b0;
        end
    end

    // Issue-side set is applied after writeback clear so it wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (fire && is_load) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_valid_q && hazard_w && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_inst_q   <= 32'h0;
            id_pc_q     <= 32'h0;
            busy_q      <= 32'h0;
            stall_cnt_q <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_w;
    assign out_inst  = id_inst_q;
    assign out_pc    = id_pc_q;
    assign hazard    = hazard_w;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_issue_ctrl
// Purpose : Directed plus randomized bench for id_issue_ctrl with a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_issue_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_inst, in_pc, out_inst, out_pc;
    logic             flush, wb_valid, hazard;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    bit rst_nxt;

    always #5 clk = ~clk;

    id_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register usage per opcode as a list of facts about each instruction class.
    function automatic void decode(input logic [31:0] inst, output bit u1, output bit u2,
                                   output bit wr, output bit ld);
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        case (inst[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: wr = 1;
            7'b1100111:                         begin u1 = 1; wr = 1; end
            7'b1100011, 7'b0100011:             begin u1 = 1; u2 = 1; end
            7'b0000011:                         begin u1 = 1; wr = 1; ld = 1; end
            7'b0010011:                         begin u1 = 1; wr = 1; end
            7'b0110011:                         begin u1 = 1; u2 = 1; wr = 1; end
            default: ;
        endcase
    endfunction

    bit          m_v;
    logic [31:0] m_inst, m_pc;
    bit          m_busy [32];
    int          m_cnt;

    always @(negedge clk) begin : cmp
        bit u1, u2, wr, ld, hz, ov, fr, ir;
        if (rst) begin
            m_v = 0; m_inst = 0; m_pc = 0; m_cnt = 0;
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_hazard", hazard, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
            chk("rst_out_inst", out_inst, 0);
            chk("rst_out_pc", out_pc, 0);
        end else begin
            decode(m_inst, u1, u2, wr, ld);
            hz = m_v && ((u1 && m_busy[m_inst[19:15]]) || (u2 && m_busy[m_inst[24:20]]) ||
                         (wr && m_busy[m_inst[11:7]]));
            ov = m_v && !hz && !flush;
            fr = ov && out_ready;
            ir = !flush && (!m_v || fr);
            chk("out_valid", out_valid, ov);
            chk("in_ready", in_ready, ir);
            chk("hazard", hazard, hz);
            chk("stall_cnt", stall_cnt, m_cnt);
            if (m_v) begin
                chk("out_inst", out_inst, m_inst);
                chk("out_pc", out_pc, m_pc);
            end
            if (m_v && hz && !flush && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (wb_valid) m_busy[wb_rd] = 0;
            if (fr && ld && m_inst[11:7] != 0) m_busy[m_inst[11:7]] = 1;
            if (flush) m_v = 0;
            else if (in_valid && ir) begin m_v = 1; m_inst = in_inst; m_pc = in_pc; end
            else if (fr) m_v = 0;
        end
    end

    task automatic tick(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit wv, input logic [4:0] wrd);
        @(posedge clk);
        #1;
        rst = rst_nxt; in_valid = iv; in_inst = inst; in_pc = pc;
        out_ready = ordy; flush = fl; wb_valid = wv; wb_rd = wrd;
        #1;
    endtask

    task automatic idle(input bit wv = 0, input logic [4:0] wrd = 0);
        tick(0, 32'h0, 32'h0, 1, 0, wv, wrd);
    endtask

    localparam logic [31:0] ADD  = 32'h00128333;
    localparam logic [31:0] LW5  = 32'h0002A283;
    localparam logic [31:0] LW0  = 32'h0002A003;
    localparam logic [31:0] ADD0 = 32'h00000333;
    localparam logic [31:0] LW7  = 32'h00002383;
    localparam logic [31:0] ADD8 = 32'h00038433;

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

    initial begin
        rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 1;
        flush = 0; wb_valid = 0; wb_rd = 0;
        rst_nxt = 1;
        idle();
        chk("lit_rst_valid", out_valid, 0);
        chk("lit_rst_ready", in_ready, 1);
        chk("lit_rst_cnt", stall_cnt, 0);

        rst_nxt = 0;
        tick(1, ADD, 32'd100, 1, 0, 0, 0);
        tick(1, LW5, 32'd104, 1, 0, 0, 0);
        chk("lit_add_valid", out_valid, 1);
        chk("lit_add_inst", out_inst, ADD);
        tick(1, ADD, 32'd108, 1, 0, 0, 0);
        idle();
        chk("lit_lu_hazard", hazard, 1);
        chk("lit_lu_cnt0", stall_cnt, 0);
        idle();
        idle();
        chk("lit_lu_cnt2", stall_cnt, 2);
        idle(1, 5);
        chk("lit_lu_wb_still_blocked", out_valid, 0);
        idle();
        chk("lit_lu_released", out_valid, 1);
        chk("lit_lu_cnt4", stall_cnt, 4);

        tick(1, LW0, 32'd112, 1, 0, 0, 0);
        tick(1, ADD0, 32'd116, 1, 0, 0, 0);
        idle();
        chk("lit_x0_no_hazard", hazard, 0);
        chk("lit_x0_valid", out_valid, 1);

        tick(1, 32'h00100093, 32'd120, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1, 32'h00200113, 32'd124, 0, 0, 0, 0);
            chk("lit_bp_inst", out_inst, 32'h00100093);
            chk("lit_bp_pc", out_pc, 32'd120);
            chk("lit_bp_in_ready", in_ready, 0);
        end
        tick(1, 32'h00200113, 32'd124, 1, 0, 0, 0);
        chk("lit_bp_release_ready", in_ready, 1);
        idle();
        chk("lit_bp_next_inst", out_inst, 32'h00200113);

        tick(1, LW5, 32'd128, 1, 0, 0, 0);
        tick(1, ADD, 32'd132, 1, 0, 0, 0);
        idle();
        tick(0, 32'h0, 32'h0, 1, 1, 0, 0);
        chk("lit_fl_valid", out_valid, 0);
        chk("lit_fl_ready", in_ready, 0);
        idle();
        chk("lit_fl_after_ready", in_ready, 1);
        tick(1, ADD, 32'd136, 1, 0, 0, 0);
        idle();
        chk("lit_fl_busy_kept", hazard, 1);
        idle(1, 5);
        idle();
        chk("lit_fl_busy_cleared", out_valid, 1);

        tick(1, LW7, 32'd140, 1, 0, 0, 0);
        tick(1, ADD8, 32'd144, 1, 0, 1, 7);
        idle();
        chk("lit_setwins_hazard", hazard, 1);
        for (int k = 0; k < 18; k++) idle();
        chk("lit_cnt_saturated", stall_cnt, 4'hF);
        idle(1, 7);
        idle();
        chk("lit_x7_released", out_valid, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] inst;
            bit          fl;
            rst_nxt = ($urandom_range(0, 199) == 0);
            inst = {$urandom_range(0, 127), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
            inst[31:25] = 7'($urandom);
            fl = !rst_nxt && ($urandom_range(0, 99) < 8);
            tick($urandom_range(0, 9) < 7, inst, $urandom, $urandom_range(0, 3) != 0, fl,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
        end
        rst_nxt = 0;
        for (int k = 0; k < 4; k++) idle();
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
